// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage with PC, req/gnt/rvalid fetch port, in-order prefetch FIFO and redirect flush.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] idata,
  output logic [31:0] iaddr,
  output logic [31:0] pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state, state_n;
  // Slots are allocated at grant (wr), filled at response (fill), retired at pop (rd).
  ptr_t wr, fill, rd, drop, drop_n, outstanding;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] addr_q [FIFO_DEPTH];
  logic pop, accept, discard, consume;
  assign outstanding = wr - fill;
  assign instr_valid = fill != rd;
  assign pop = instr_valid && instr_ready;
  // A pop this cycle frees a slot, so issue can continue back-to-back without overflow.
  assign imem_req = state == FETCH && !redirect && ptr_t'(wr - rd - ptr_t'(pop)) < ptr_t'(FIFO_DEPTH);
  assign accept = imem_req && imem_gnt;
  assign discard = imem_rvalid && drop != '0;
  assign consume = imem_rvalid && drop == '0 && outstanding != '0;
  assign imem_addr = pc;
  assign idata = instr_valid ? data_q[rd[AW-1:0]] : '0;
  assign iaddr = instr_valid ? addr_q[rd[AW-1:0]] : '0;
  always_comb begin
    drop_n = drop - ptr_t'(discard);
    drop_n = redirect ? drop_n + outstanding - ptr_t'(consume) : drop_n;
    state_n = state == IDLE  ? FETCH :
              state == FETCH ? ((redirect && drop_n != '0) ? FLUSH : FETCH) :
              ((redirect || drop_n != '0) ? FLUSH : FETCH);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      wr    <= '0;
      fill  <= '0;
      rd    <= '0;
      drop  <= '0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (redirect) begin
        pc   <= redirect_pc & ~32'h3;
        wr   <= '0;
        fill <= '0;
        rd   <= '0;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
          wr <= wr + 1'b1;
        end
        if (consume) fill <= fill + 1'b1;
        if (pop) rd <= rd + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) addr_q[wr[AW-1:0]] <= pc;
    if (consume) data_q[fill[AW-1:0]] <= imem_rdata;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit with an in-order memory model.
module tb_instr_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_A5A5;
  logic clk = 1'b0;
  logic reset;
  logic imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, idata, iaddr, pc;
  logic req2, valid2;
  logic [31:0] addr2, idata2, iaddr2, pc2;
  logic rv_m = 1'b0, rv_ovr, resp_en, acc_s = 1'b0;
  logic [31:0] rd_m = '0, addr_s = '0;
  logic [31:0] mq [$];
  logic [63:0] got [$];
  int grants = 0, n_asrt = 0, n_fail = 0, base;

  always #5 clk = ~clk;
  assign imem_rvalid = rv_ovr | rv_m;
  assign imem_rdata  = rv_ovr ? 32'hDEAD_BEEF : rd_m;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .idata(idata), .iaddr(iaddr), .pc(pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b0),
    .imem_rvalid(1'b0), .imem_rdata(32'h0), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(valid2), .instr_ready(1'b1), .idata(idata2), .iaddr(iaddr2), .pc(pc2)
  );

  // Memory: grants sampled mid-cycle, one-cycle in-order response while resp_en is set.
  always @(negedge clk) begin
    acc_s  = imem_req && imem_gnt;
    addr_s = imem_addr;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      rv_m <= 1'b0;
    end else begin
      if (acc_s) mq.push_back(addr_s);
      if (resp_en && mq.size() > 0) begin
        rv_m <= 1'b1;
        rd_m <= mq.pop_front() ^ K;
      end else rv_m <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      got.delete();
      grants = 0;
    end else begin
      if (instr_valid && instr_ready) got.push_back({iaddr, idata});
      if (imem_req && imem_gnt) grants++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [31:0] a);
    chk({tag, "_n"}, 64'(got.size() > idx), 64'd1);
    if (got.size() > idx) chk(tag, got[idx], {a, a ^ K});
  endtask

  initial begin
    reset = 1; imem_gnt = 1; instr_ready = 1; redirect = 0; redirect_pc = '0; resp_en = 1; rv_ovr = 0;
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_idata", 64'(idata), 64'd0);
    chk("rst_iaddr", 64'(iaddr), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_pc2", 64'(pc2), 64'hFFFF_FFF8);
    chk("rst_req2", 64'(req2), 64'd0);
    // Streaming with always-ready decode
    @(posedge clk); #1; reset = 0;
    @(negedge clk); chk("idle_req", 64'(imem_req), 64'd0);
    cyc(1);
    @(negedge clk);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", 64'(imem_addr), 64'd0);
    chk("req2", 64'(req2), 64'd1);
    chk("addr2", 64'(addr2), 64'hFFFF_FFF8);
    cyc(1);
    @(negedge clk); chk("valid_c2", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      @(negedge clk);
      chk("stream_valid", 64'(instr_valid), 64'd1);
      chk("stream_iaddr", 64'(iaddr), 64'(32'(4 * k)));
      chk("stream_idata", 64'(idata), 64'(32'(4 * k) ^ K));
    end
    // Decode stalled: credit limit stops issue after FIFO_DEPTH grants
    cyc(1); instr_ready = 0; reset = 1;
    cyc(1); reset = 0;
    cyc(10);
    @(negedge clk);
    chk("stall_grants", 64'(grants), 64'd2);
    chk("stall_req", 64'(imem_req), 64'd0);
    chk("stall_valid", 64'(instr_valid), 64'd1);
    chk("stall_iaddr", 64'(iaddr), 64'd0);
    chk("stall_idata", 64'(idata), 64'(K));
    cyc(1);
    @(negedge clk); chk("stall_hold", {iaddr, idata}, {32'd0, K});
    cyc(1); instr_ready = 1;
    cyc(8);
    chk("drain_cnt", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_got("drain", i, 32'(4 * i));
    // Grant withheld: request and address held steady
    imem_gnt = 0; reset = 1;
    cyc(1); reset = 0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nognt_req", 64'(imem_req), 64'd1);
      chk("nognt_addr", 64'(imem_addr), 64'd0);
      chk("nognt_pc", 64'(pc), 64'd0);
      cyc(1);
    end
    imem_gnt = 1;
    // Redirect with two fetches outstanding
    resp_en = 0; reset = 1;
    cyc(1); reset = 0;
    cyc(3);
    redirect = 1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir_req", 64'(imem_req), 64'd0);
    chk("redir_grants", 64'(grants), 64'd2);
    cyc(1); redirect = 0; resp_en = 1; base = got.size();
    @(negedge clk);
    chk("flush_valid", 64'(instr_valid), 64'd0);
    chk("flush_pc", 64'(pc), 64'h100);
    chk("flush_req0", 64'(imem_req), 64'd0);
    cyc(1);
    @(negedge clk); chk("flush_req1", 64'(imem_req), 64'd0);
    cyc(1);
    @(negedge clk); chk("flush_req2", 64'(imem_req), 64'd0);
    cyc(1);
    @(negedge clk);
    chk("refetch_req", 64'(imem_req), 64'd1);
    chk("refetch_addr", 64'(imem_addr), 64'h100);
    cyc(6);
    chk_got("redir_first", base, 32'h100);
    chk_got("redir_second", base + 1, 32'h104);
    // PC wrap via redirect mid-stream
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    cyc(1); redirect = 0; base = got.size();
    cyc(12);
    chk_got("wrap0", base, 32'hFFFF_FFF8);
    chk_got("wrap1", base + 1, 32'hFFFF_FFFC);
    chk_got("wrap2", base + 2, 32'h0000_0000);
    // Asynchronous reset mid-stream with a response on the bus
    #3; reset = 1; rv_ovr = 1;
    #1;
    chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_idata", 64'(idata), 64'd0);
    chk("arst_iaddr", 64'(iaddr), 64'd0);
    chk("arst_pc", 64'(pc), 64'd0);
    @(posedge clk); #1; reset = 0;
    cyc(1);
    @(negedge clk);
    chk("restart_req", 64'(imem_req), 64'd1);
    chk("restart_addr", 64'(imem_addr), 64'd0);
    cyc(1); rv_ovr = 0;
    cyc(6);
    chk_got("restart0", 0, 32'h0);
    chk_got("restart1", 1, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
